// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes,
// status encodings and memory-stage FSM state type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_DONE
    } mem_state_t;

endpackage

// File: rtl/mem_access_decode.sv
// Combinational icode classifier for the memory stage.
// in: icode; out: is_read, is_write, addr_sel (1=valA),
// data_sel (1=valP), stat_pre (HLT/INS/AOK).
module mem_access_decode
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic       is_read,
    output logic       is_write,
    output logic       addr_sel,
    output logic       data_sel,
    output logic [1:0] stat_pre
);

    always_comb begin
        is_read  = 1'b0;
        is_write = 1'b0;
        addr_sel = 1'b0;
        data_sel = 1'b0;
        stat_pre = STAT_AOK;
        unique case (1'b1)
            (icode == I_RMMOVQ),
            (icode == I_PUSHQ): begin
                is_write = 1'b1;
            end
            (icode == I_CALL): begin
                is_write = 1'b1;
                data_sel = 1'b1;
            end
            (icode == I_MRMOVQ): begin
                is_read = 1'b1;
            end
            (icode == I_RET),
            (icode == I_POPQ): begin
                is_read  = 1'b1;
                addr_sel = 1'b1;
            end
            (icode == I_HALT): begin
                stat_pre = STAT_HLT;
            end
            (icode > I_POPQ): begin
                stat_pre = STAT_INS;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// SEQ Y86-64 memory stage: latches execute results, runs one
// data-memory access over a req/ack handshake, returns valm/stat.
// Ports: clk, rst_n, start, icode, vale, vala, valp -> busy, done,
// valm, stat; dmem_req/we/addr/wdata out, dmem_rdata/ack in.
// Optional MEM_TIMEOUT_EN: ack watchdog of TIMEOUT_CYCLES in REQ.
module mem_stage_ctrl
    import y86_pkg::*;
#(
    parameter int ADDR_W         = 64,
    parameter int MEM_BYTES      = 1024,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        icode,
    input  logic [ADDR_W-1:0] vale,
    input  logic [ADDR_W-1:0] vala,
    input  logic [ADDR_W-1:0] valp,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] valm,
    output logic [1:0]        stat,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [ADDR_W-1:0] dmem_wdata,
    input  logic [ADDR_W-1:0] dmem_rdata,
    input  logic              dmem_ack
);

    localparam logic [ADDR_W-1:0] MAX_ADDR =
        ADDR_W'(MEM_BYTES - 8);

    mem_state_t        state;
    logic [3:0]        icode_q;
    logic [ADDR_W-1:0] vale_q;
    logic [ADDR_W-1:0] vala_q;
    logic [ADDR_W-1:0] valp_q;

    logic              d_read;
    logic              d_write;
    logic              d_asel;
    logic              d_dsel;
    logic [1:0]        d_stat;

    logic [ADDR_W-1:0] acc_addr;
    logic [ADDR_W-1:0] acc_data;
    logic              acc_oob;
    logic              accept;

    mem_access_decode u_dec (
        .icode    (icode_q),
        .is_read  (d_read),
        .is_write (d_write),
        .addr_sel (d_asel),
        .data_sel (d_dsel),
        .stat_pre (d_stat)
    );

    assign acc_addr = d_asel ? vala_q : vale_q;
    assign acc_data = d_dsel ? valp_q : vala_q;
    assign acc_oob  = acc_addr > MAX_ADDR;

    // DONE counts as free so a new op can follow with no gap.
    assign accept = start &&
        ((state == S_IDLE) || (state == S_DONE));

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            icode_q    <= 4'h0;
            vale_q     <= '0;
            vala_q     <= '0;
            valp_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            valm       <= '0;
            stat       <= STAT_AOK;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
`ifdef MEM_TIMEOUT_EN
            tcnt       <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                icode_q <= icode;
                vale_q  <= vale;
                vala_q  <= vala;
                valp_q  <= valp;
                busy    <= 1'b1;
                valm    <= '0;
                stat    <= STAT_AOK;
                state   <= S_CHECK;
            end else begin
                unique case (state)
                    S_IDLE: ;
                    S_CHECK: begin
                        // Non-access ops still pass through REQ
                        // (with req low) so every op without ack
                        // wait has the same latency.
                        state <= S_REQ;
`ifdef MEM_TIMEOUT_EN
                        tcnt  <= '0;
`endif
                        if (d_stat != STAT_AOK) begin
                            stat <= d_stat;
                        end else if (d_read || d_write) begin
                            if (acc_oob) begin
                                stat <= STAT_ADR;
                            end else begin
                                dmem_req   <= 1'b1;
                                dmem_we    <= d_write;
                                dmem_addr  <= acc_addr;
                                dmem_wdata <= acc_data;
                            end
                        end
                    end
                    S_REQ: begin
                        if (!dmem_req) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (dmem_ack) begin
                            dmem_req <= 1'b0;
                            dmem_we  <= 1'b0;
                            if (!dmem_we) begin
                                valm <= dmem_rdata;
                            end
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
`ifdef MEM_TIMEOUT_EN
                        else if (tcnt == TLIM) begin
                            dmem_req <= 1'b0;
                            dmem_we  <= 1'b0;
                            stat     <= STAT_ADR;
                            valm     <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
`endif
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl.
// Memory responder is modelled inline in run_op.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'h0;
    logic [63:0] vale = '0;
    logic [63:0] vala = '0;
    logic [63:0] valp = '0;
    logic        busy;
    logic        done;
    logic [63:0] valm;
    logic [1:0]  stat;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    int          r_done;
    int          r_nreq;
    logic [63:0] r_addr;
    logic        r_we;
    logic [63:0] r_wdata;

    always #5 clk = ~clk;

    mem_stage_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .icode      (icode),
        .vale       (vale),
        .vala       (vala),
        .valp       (valp),
        .busy       (busy),
        .done       (done),
        .valm       (valm),
        .stat       (stat),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    // Cycle 0 is the start cycle; r_done is the cycle in which
    // done is seen high (-1 if not within lim). dly<0: no ack.
    task automatic run_op(input logic [3:0] ic,
                          input logic [63:0] e,
                          input logic [63:0] a,
                          input logic [63:0] p,
                          input int dly,
                          input logic [63:0] rd,
                          input bit b2b,
                          input int lim);
        int w;
        w = 0;
        r_done = -1;
        r_nreq = 0;
        r_addr = '0;
        r_we = 1'b0;
        r_wdata = '0;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        icode = ic;
        vale = e;
        vala = a;
        valp = p;
        start = 1'b1;
        for (int k = 1; k <= lim; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            if (dmem_req) begin
                r_nreq++;
                r_addr = dmem_addr;
                r_we = dmem_we;
                r_wdata = dmem_wdata;
                if (dly >= 0 && w == dly) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rd;
                end else begin
                    dmem_ack = 1'b0;
                end
                w++;
            end else begin
                dmem_ack = 1'b0;
            end
            if (done) begin
                r_done = k;
                break;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_req", 64'(dmem_req), 64'd0);
        chk("rst_we", 64'(dmem_we), 64'd0);
        chk("rst_valm", valm, 64'd0);
        chk("rst_addr", dmem_addr, 64'd0);
        chk("rst_wdata", dmem_wdata, 64'd0);
        chk("rst_stat", 64'(stat), 64'd0);
        rst_n = 1'b1;

        // rmmovq, ack after 2 wait cycles
        run_op(4'h4, 64'h100, 64'hDEADBEEF, 64'h0,
               2, 64'h0, 1'b0, 50);
        chk("rm_lat", 64'(r_done), 64'd5);
        chk("rm_nreq", 64'(r_nreq), 64'd3);
        chk("rm_addr", r_addr, 64'h100);
        chk("rm_we", 64'(r_we), 64'd1);
        chk("rm_wd", r_wdata, 64'hDEADBEEF);
        chk("rm_stat", 64'(stat), 64'd0);
        chk("rm_valm", valm, 64'd0);
        chk("rm_busy", 64'(busy), 64'd0);

        // popq, immediate ack
        run_op(4'hB, 64'h999, 64'h3F8, 64'h0,
               0, 64'h1234, 1'b0, 50);
        chk("pop_lat", 64'(r_done), 64'd3);
        chk("pop_addr", r_addr, 64'h3F8);
        chk("pop_we", 64'(r_we), 64'd0);
        chk("pop_nreq", 64'(r_nreq), 64'd1);
        chk("pop_valm", valm, 64'h1234);
        chk("pop_stat", 64'(stat), 64'd0);

        // mrmovq just past the end of memory
        run_op(4'h5, 64'h3F9, 64'h0, 64'h0,
               0, 64'h5555, 1'b0, 50);
        chk("oob_lat", 64'(r_done), 64'd3);
        chk("oob_nreq", 64'(r_nreq), 64'd0);
        chk("oob_stat", 64'(stat), 64'd2);
        chk("oob_valm", valm, 64'd0);

        // mrmovq at last legal word, 1 wait cycle
        run_op(4'h5, 64'h3F8, 64'h7, 64'h0,
               1, 64'hCAFE, 1'b0, 50);
        chk("mr_lat", 64'(r_done), 64'd4);
        chk("mr_addr", r_addr, 64'h3F8);
        chk("mr_valm", valm, 64'hCAFE);

        // call writes valP at valE; valm cleared
        run_op(4'h8, 64'h200, 64'h11, 64'h55,
               0, 64'h0, 1'b0, 50);
        chk("call_addr", r_addr, 64'h200);
        chk("call_wd", r_wdata, 64'h55);
        chk("call_we", 64'(r_we), 64'd1);
        chk("call_valm", valm, 64'd0);

        // ret reads at valA
        run_op(4'h9, 64'h300, 64'h10, 64'h0,
               0, 64'h77, 1'b0, 50);
        chk("ret_addr", r_addr, 64'h10);
        chk("ret_valm", valm, 64'h77);

        // pushq writes valA at valE; start in done cycle
        run_op(4'hA, 64'h3F8, 64'hAB, 64'h99,
               0, 64'h0, 1'b1, 50);
        chk("push_lat", 64'(r_done), 64'd3);
        chk("push_wd", r_wdata, 64'hAB);
        chk("push_nreq", 64'(r_nreq), 64'd1);

        // halt / invalid / opq / far address without wrap
        run_op(4'h0, 64'h0, 64'h0, 64'h0, 0, 64'h0, 1'b0, 50);
        chk("hlt_stat", 64'(stat), 64'd1);
        chk("hlt_nreq", 64'(r_nreq), 64'd0);
        chk("hlt_lat", 64'(r_done), 64'd3);
        run_op(4'hC, 64'h0, 64'h0, 64'h0, 0, 64'h0, 1'b0, 50);
        chk("ins_stat", 64'(stat), 64'd3);
        chk("ins_nreq", 64'(r_nreq), 64'd0);
        run_op(4'h6, 64'h8, 64'h8, 64'h0, 0, 64'h0, 1'b0, 50);
        chk("op_stat", 64'(stat), 64'd0);
        chk("op_nreq", 64'(r_nreq), 64'd0);
        run_op(4'hF, 64'h8, 64'h8, 64'h0, 0, 64'h0, 1'b1, 50);
        chk("insf_stat", 64'(stat), 64'd3);
        run_op(4'h8, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h1,
               0, 64'h0, 1'b0, 50);
        chk("wrap_stat", 64'(stat), 64'd2);
        chk("wrap_nreq", 64'(r_nreq), 64'd0);

        // start during REQ ignored, then reset in REQ
        @(posedge clk);
        #1;
        icode = 4'h4;
        vale = 64'h300;
        vala = 64'h11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        icode = 4'h5;
        vale = 64'h8;
        vala = 64'h99;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("ign_req", 64'(dmem_req), 64'd1);
        chk("ign_addr", dmem_addr, 64'h300);
        chk("ign_wd", dmem_wdata, 64'h11);
        chk("ign_we", 64'(dmem_we), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_req", 64'(dmem_req), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_addr", dmem_addr, 64'd0);
        chk("ar_we", 64'(dmem_we), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 64'hBAD;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        chk("late_done", 64'(done), 64'd0);
        chk("late_busy", 64'(busy), 64'd0);
        chk("late_valm", valm, 64'd0);
        chk("late_stat", 64'(stat), 64'd0);

        // call with no ack
`ifdef MEM_TIMEOUT_EN
        run_op(4'h8, 64'h40, 64'h0, 64'h5, -1, 64'h0, 1'b0, 60);
        chk("to_nreq", 64'(r_nreq), 64'd16);
        chk("to_lat", 64'(r_done), 64'd18);
        chk("to_stat", 64'(stat), 64'd2);
        chk("to_valm", valm, 64'd0);
        chk("to_req", 64'(dmem_req), 64'd0);
`else
        run_op(4'h8, 64'h40, 64'h0, 64'h5, -1, 64'h0, 1'b0, 101);
        chk("hang_nreq", 64'(r_nreq), 64'd100);
        chk("hang_req", 64'(dmem_req), 64'd1);
        chk("hang_done", 64'(r_done == -1), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("hang_rst", 64'(dmem_req), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
